hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_entry_pipe.sv | 43 ++++
 rtl/hazard_scoreboard.sv | 102 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and the in-flight writer record for the hazard scoreboard.
package hazard_pkg;

  localparam logic [4:0]  HALT_OPC   = 5'b00001;
  localparam int unsigned REG_AW_DEF = 3;
  localparam int unsigned DEPTH_DEF  = 2;
  // Widest register address an entry can hold; narrower addresses are zero-extended.
  localparam int unsigned MAX_REG_AW = 8;

  typedef struct packed {
    logic                  valid;
    logic                  load;
    logic [MAX_REG_AW-1:0] addr;
  } entry_t;

endpackage

// File: rtl/hazard_entry_pipe.sv
// Shift register of in-flight writers behind ID; holds on freeze and
// inserts a bubble at entry 0 whenever nothing issues.
module hazard_entry_pipe
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_freeze,
  input  logic                    i_issue,
  input  logic [REG_AW-1:0]       i_addr,
  input  logic                    i_load,
  output entry_t [DEPTH-1:0]      o_entries
);

  entry_t [DEPTH-1:0] r_entries;
  entry_t             w_new;

  always_comb begin
    w_new       = '0;
    w_new.valid = i_issue;
    w_new.load  = i_load;
    w_new.addr  = MAX_REG_AW'(i_addr);
  end

  // The oldest entry simply falls off the end: the register file is
  // write-before-read, so it no longer needs tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entries <= '0;
    end else if (!i_freeze) begin
      r_entries[0] <= w_new;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_entries[i] <= r_entries[i-1];
      end
    end
  end

  assign o_entries = r_entries;

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard detection: compares ID sources against in-flight writers,
// drives stall, the pending-register mask and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned FWD_EN = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [4:0]             opcode_id,
  input  logic [REG_AW-1:0]      rs_id,
  input  logic [REG_AW-1:0]      rt_id,
  input  logic                   rs_used,
  input  logic                   rt_used,
  input  logic                   wr_en_id,
  input  logic [REG_AW-1:0]      wr_reg_id,
  input  logic                   is_load_id,
  input  logic                   br_taken_id,
  input  logic                   freeze,
  input  logic                   flush,
  output logic                   stall,
  output logic [2**REG_AW-1:0]   pending,
  output logic [CNT_W-1:0]       stall_cnt
);

  entry_t [DEPTH-1:0]    w_entries;
  logic [MAX_REG_AW-1:0] w_rs;
  logic [MAX_REG_AW-1:0] w_rt;
  logic [DEPTH-1:0]      w_hit;
  logic                  w_raw;
  logic                  w_stall;
  logic                  w_issue;
  logic [2**REG_AW-1:0]  w_pending;
  logic                  w_unused_load;
  logic [CNT_W-1:0]      r_stall_cnt;

  assign w_rs = MAX_REG_AW'(rs_id);
  assign w_rt = MAX_REG_AW'(rt_id);

  always_comb begin
    w_hit = '0;
    w_raw = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_hit[i] = (rs_used & w_entries[i].valid & (w_entries[i].addr == w_rs)) |
                 (rt_used & w_entries[i].valid & (w_entries[i].addr == w_rt));
    end
    // With forwarding only a load still in EX cannot supply its result in time.
    if (FWD_EN != 0) begin
      w_raw = w_hit[0] & w_entries[0].load;
    end else begin
      w_raw = |w_hit;
    end
  end

  assign w_stall = id_valid & w_raw & ~br_taken_id & ~flush & (opcode_id != HALT_OPC);
  assign w_issue = id_valid & wr_en_id & ~w_stall & ~flush;

  always_comb begin
    w_pending     = '0;
    w_unused_load = 1'b0;
    for (int r = 0; r < 2**REG_AW; r++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (w_entries[i].valid && (w_entries[i].addr == MAX_REG_AW'(r))) begin
          w_pending[r] = 1'b1;
        end
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_unused_load = w_unused_load ^ w_entries[i].load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !freeze && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  hazard_entry_pipe #(
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_freeze  (freeze),
    .i_issue   (w_issue),
    .i_addr    (wr_reg_id),
    .i_load    (is_load_id),
    .o_entries (w_entries)
  );

  assign stall     = w_stall;
  assign pending   = w_pending;
  assign stall_cnt = r_stall_cnt;

endmodule
